// File: rtl/ps2_key_decoder_pkg.sv
// Scan-code constants and frame FSM encoding shared by the PS/2 decoder
// and the game controller's keyboard-driven transitions.
package ps2_key_decoder_pkg;

   localparam logic [7:0] SC_EXT  = 8'hE0;
   localparam logic [7:0] SC_REL  = 8'hF0;
   localparam logic [7:0] SC_UP   = 8'h75;
   localparam logic [7:0] SC_DOWN = 8'h72;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } ps2_state_e;

   // Odd parity over data plus parity bit, and a high stop bit.
   function automatic logic frame_ok(input logic [7:0] data, input logic parity, input logic stop);
      return stop & (^{data, parity});
   endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// Brings raw PS/2 clock/data into the clk domain, debounces k_clk and
// emits a one-cycle strobe on each falling edge of the filtered clock.
module ps2_sync_filter #(
   parameter int FILTER_LEN = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic k_clk_i,
   input  logic k_data_i,
   output logic data_o,
   output logic strobe_o
);

   localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

   logic [1:0]    clk_sync_q;
   logic [1:0]    data_sync_q;
   logic          filt_q, filt_d;
   logic          filt_dly_q;
   logic [CW-1:0] cnt_q, cnt_d;

   // cnt_q counts consecutive samples disagreeing with the filtered level.
   always_comb begin
      filt_d = filt_q;
      cnt_d  = '0;
      if (clk_sync_q[1] != filt_q) begin
         if (cnt_q == CW'(FILTER_LEN - 1)) begin
            filt_d = clk_sync_q[1];
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         clk_sync_q  <= 2'b11;
         data_sync_q <= 2'b11;
         filt_q      <= 1'b1;
         filt_dly_q  <= 1'b1;
         cnt_q       <= '0;
      end else begin
         clk_sync_q  <= {clk_sync_q[0], k_clk_i};
         data_sync_q <= {data_sync_q[0], k_data_i};
         filt_q      <= filt_d;
         filt_dly_q  <= filt_q;
         cnt_q       <= cnt_d;
      end
   end

   assign strobe_o = filt_dly_q & ~filt_q;
   assign data_o   = data_sync_q[1];

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard frame receiver with E0/F0 prefix tracking and
// up/down arrow make detection.
import ps2_key_decoder_pkg::*;

module ps2_key_decoder #(
   parameter int TIMEOUT_CYC = 50000,
   parameter int FILTER_LEN  = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       k_clk,
   input  logic       k_data,
   output logic [7:0] code,
   output logic       code_valid,
   output logic       extended,
   output logic       released,
   output logic       up,
   output logic       down,
   output logic       frame_err
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   logic       strobe;
   logic       sdata;

   ps2_state_e state_q, state_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] shift_q, shift_d;
   logic       parity_q, parity_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [7:0] code_q, code_d;
   logic       valid_q, valid_d;
   logic       ext_q, ext_d;
   logic       rel_q, rel_d;
   logic       up_q, up_d;
   logic       down_q, down_d;
   logic       err_q, err_d;
   logic       pend_ext_q, pend_ext_d;
   logic       pend_rel_q, pend_rel_d;

   ps2_sync_filter #(
      .FILTER_LEN(FILTER_LEN)
   ) u_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .k_clk_i (k_clk),
      .k_data_i(k_data),
      .data_o  (sdata),
      .strobe_o(strobe)
   );

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      parity_d   = parity_q;
      tmo_d      = '0;
      code_d     = code_q;
      ext_d      = ext_q;
      rel_d      = rel_q;
      pend_ext_d = pend_ext_q;
      pend_rel_d = pend_rel_q;
      valid_d    = 1'b0;
      up_d       = 1'b0;
      down_d     = 1'b0;
      err_d      = 1'b0;

      if (state_q == ST_IDLE) begin
         bit_cnt_d = '0;
         if (strobe && !sdata) begin
            state_d = ST_DATA;
         end
      end else if (strobe) begin
         // A strobe always beats the timeout terminal count.
         if (state_q == ST_DATA) begin
            shift_d   = {sdata, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
               state_d = ST_PARITY;
            end
         end else if (state_q == ST_PARITY) begin
            parity_d = sdata;
            state_d  = ST_STOP;
         end else begin
            state_d = ST_IDLE;
            if (!frame_ok(shift_q, parity_q, sdata)) begin
               err_d      = 1'b1;
               pend_ext_d = 1'b0;
               pend_rel_d = 1'b0;
            end else if (shift_q == SC_EXT) begin
               pend_ext_d = 1'b1;
            end else if (shift_q == SC_REL) begin
               pend_rel_d = 1'b1;
            end else begin
               code_d     = shift_q;
               valid_d    = 1'b1;
               ext_d      = pend_ext_q;
               rel_d      = pend_rel_q;
               up_d       = (shift_q == SC_UP)   && pend_ext_q && !pend_rel_q;
               down_d     = (shift_q == SC_DOWN) && pend_ext_q && !pend_rel_q;
               pend_ext_d = 1'b0;
               pend_rel_d = 1'b0;
            end
         end
      end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
         state_d    = ST_IDLE;
         err_d      = 1'b1;
         pend_ext_d = 1'b0;
         pend_rel_d = 1'b0;
      end else begin
         tmo_d = tmo_q + TW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         parity_q   <= 1'b0;
         tmo_q      <= '0;
         code_q     <= '0;
         valid_q    <= 1'b0;
         ext_q      <= 1'b0;
         rel_q      <= 1'b0;
         up_q       <= 1'b0;
         down_q     <= 1'b0;
         err_q      <= 1'b0;
         pend_ext_q <= 1'b0;
         pend_rel_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         parity_q   <= parity_d;
         tmo_q      <= tmo_d;
         code_q     <= code_d;
         valid_q    <= valid_d;
         ext_q      <= ext_d;
         rel_q      <= rel_d;
         up_q       <= up_d;
         down_q     <= down_d;
         err_q      <= err_d;
         pend_ext_q <= pend_ext_d;
         pend_rel_q <= pend_rel_d;
      end
   end

   assign code       = code_q;
   assign code_valid = valid_q;
   assign extended   = ext_q;
   assign released   = rel_q;
   assign up         = up_q;
   assign down       = down_q;
   assign frame_err  = err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Drives PS/2 frames into ps2_key_decoder and compares output pulses and
// qualifiers against a byte-level prefix model.
module tb_ps2_key_decoder;

   localparam int H = 10;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       k_clk = 1'b1;
   logic       k_data = 1'b1;
   logic [7:0] code;
   logic       code_valid, extended, released, up, down, frame_err;

   int tests = 0;
   int failed = 0;

   int cyc = 0;
   int valid_cnt = 0;
   int err_cnt = 0;
   int up_cnt = 0;
   int down_cnt = 0;
   int strobe_cnt = 0;
   int last_strobe = 0;
   int last_lat = -1;

   logic       m_pe = 1'b0;
   logic       m_pr = 1'b0;
   logic       m_ext = 1'b0;
   logic       m_rel = 1'b0;
   logic [7:0] m_code = 8'h00;

   always #5 clk = ~clk;

   ps2_key_decoder dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .k_clk     (k_clk),
      .k_data    (k_data),
      .code      (code),
      .code_valid(code_valid),
      .extended  (extended),
      .released  (released),
      .up        (up),
      .down      (down),
      .frame_err (frame_err)
   );

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (dut.strobe) begin
         strobe_cnt  <= strobe_cnt + 1;
         last_strobe <= cyc;
      end
      if (code_valid) begin
         valid_cnt <= valid_cnt + 1;
         last_lat  <= cyc - last_strobe;
      end
      if (frame_err) err_cnt  <= err_cnt + 1;
      if (up)        up_cnt   <= up_cnt + 1;
      if (down)      down_cnt <= down_cnt + 1;
   end

   task automatic check(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [10:0] frame_bits(input logic [7:0] b, input logic bad);
      return {1'b1, (~^b) ^ bad, b, 1'b0};
   endfunction

   task automatic send_bits(input logic [10:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         k_data = bits[i];
         repeat (H) @(negedge clk);
         k_clk = 1'b0;
         repeat (H) @(negedge clk);
         k_clk = 1'b1;
      end
      k_data = 1'b1;
   endtask

   task automatic run_frame(input logic [7:0] b, input logic bad);
      int v0, e0, u0, d0;
      int xv, xe, xu, xd;
      v0 = valid_cnt; e0 = err_cnt; u0 = up_cnt; d0 = down_cnt;
      xv = 0; xe = 0; xu = 0; xd = 0;
      if (bad) begin
         xe = 1; m_pe = 1'b0; m_pr = 1'b0;
      end else if (b == 8'hE0) begin
         m_pe = 1'b1;
      end else if (b == 8'hF0) begin
         m_pr = 1'b1;
      end else begin
         xv = 1;
         m_code = b; m_ext = m_pe; m_rel = m_pr;
         xu = (b == 8'h75 && m_pe && !m_pr) ? 1 : 0;
         xd = (b == 8'h72 && m_pe && !m_pr) ? 1 : 0;
         m_pe = 1'b0; m_pr = 1'b0;
      end
      send_bits(frame_bits(b, bad), 11);
      repeat (20) @(negedge clk);
      $display("[TB] frame %02h bad=%0d -> valid=%0d err=%0d code=%02h ext=%0d rel=%0d up=%0d down=%0d",
               b, bad, valid_cnt - v0, err_cnt - e0, code, extended, released,
               up_cnt - u0, down_cnt - d0);
      check("valid_pulses", valid_cnt - v0, xv);
      check("err_pulses", err_cnt - e0, xe);
      check("up_pulses", up_cnt - u0, xu);
      check("down_pulses", down_cnt - d0, xd);
      check("code", int'(code), int'(m_code));
      check("extended", int'(extended), int'(m_ext));
      check("released", int'(released), int'(m_rel));
      if (xv == 1) check("latency", last_lat, 1);
   endtask

   initial begin
      int s0, e0, v0;
      logic [7:0] special [4];
      logic [7:0] b;
      logic       bad;
      special[0] = 8'hE0; special[1] = 8'hF0; special[2] = 8'h75; special[3] = 8'h72;

      repeat (5) @(negedge clk);
      check("rst_code", int'(code), 0);
      check("rst_valid", int'(code_valid), 0);
      check("rst_ext", int'(extended), 0);
      check("rst_rel", int'(released), 0);
      check("rst_up", int'(up), 0);
      check("rst_down", int'(down), 0);
      check("rst_err", int'(frame_err), 0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      run_frame(8'h1C, 1'b0);
      run_frame(8'hE0, 1'b0);
      run_frame(8'h75, 1'b0);
      run_frame(8'hE0, 1'b0);
      run_frame(8'hF0, 1'b0);
      run_frame(8'h72, 1'b0);
      run_frame(8'h1C, 1'b1);
      run_frame(8'h72, 1'b0);

      // Low glitches up to FILTER_LEN-1 cycles with data low must not start a frame.
      s0 = strobe_cnt;
      k_data = 1'b0;
      for (int g = 1; g <= 3; g++) begin
         k_clk = 1'b0;
         repeat (g) @(negedge clk);
         k_clk = 1'b1;
         repeat (12) @(negedge clk);
      end
      k_data = 1'b1;
      repeat (10) @(negedge clk);
      $display("[TB] glitch burst -> strobes=%0d", strobe_cnt - s0);
      check("glitch_strobes", strobe_cnt - s0, 0);
      run_frame(8'h1C, 1'b0);

      // Pending E0, then an aborted frame stalls until the timeout.
      run_frame(8'hE0, 1'b0);
      e0 = err_cnt; v0 = valid_cnt;
      send_bits(frame_bits(8'h75, 1'b0), 4);
      repeat (50020) @(negedge clk);
      $display("[TB] partial frame timeout -> err=%0d valid=%0d", err_cnt - e0, valid_cnt - v0);
      check("timeout_err", err_cnt - e0, 1);
      check("timeout_valid", valid_cnt - v0, 0);
      m_pe = 1'b0; m_pr = 1'b0;
      run_frame(8'h75, 1'b0);

      // Pending E0, then reset in the middle of a frame.
      run_frame(8'hE0, 1'b0);
      e0 = err_cnt;
      send_bits(frame_bits(8'h6B, 1'b0), 5);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      $display("[TB] mid-frame reset -> code=%02h valid=%0d ext=%0d rel=%0d err=%0d",
               code, code_valid, extended, released, err_cnt - e0);
      check("midrst_outs", int'({code, code_valid, extended, released, up, down, frame_err}), 0);
      check("midrst_err", err_cnt - e0, 0);
      rst_n = 1'b1;
      m_pe = 1'b0; m_pr = 1'b0; m_code = 8'h00; m_ext = 1'b0; m_rel = 1'b0;
      repeat (5) @(negedge clk);
      run_frame(8'h75, 1'b0);

      for (int n = 0; n < 30; n++) begin
         if ($urandom_range(0, 2) == 0) b = special[$urandom_range(0, 3)];
         else b = 8'($urandom);
         bad = ($urandom_range(0, 7) == 0);
         run_frame(b, bad);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 Parameter TIMEOUT_CYC, default 50000: clk cycles allowed between k_clk falling edges inside a frame before the frame is aborted.
REQ-002 Parameter FILTER_LEN, default 4: consecutive identical synchronized samples required before k_clk's filtered level changes.
REQ-003 clk  in  1  system clock; one clock domain for the whole block.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 k_clk  in  1  raw PS/2 clock from keyboard, asynchronous.
REQ-006 k_data  in  1  raw PS/2 data from keyboard, asynchronous.
REQ-007 code  out  8  last accepted scan-code byte.
REQ-008 code_valid  out  1  one-cycle pulse when code updates.
REQ-009 extended  out  1  qualifier of code_valid: an E0 prefix preceded this byte.
REQ-010 released  out  1  qualifier of code_valid: an F0 prefix preceded this byte.
REQ-011 up  out  1  one-cycle pulse on an up-arrow make (E0 75).
REQ-012 down  out  1  one-cycle pulse on a down-arrow make (E0 72).
REQ-013 frame_err  out  1  one-cycle pulse on a bad start, parity, stop or timeout.

Function
REQ-014 Synchronizer: k_clk and k_data SHALL pass through 2 flip-flops each.
REQ-015 Glitch filter: k_clk SHALL be filtered per FILTER_LEN.
REQ-016 Sample strobe: a falling edge of filtered k_clk SHALL produce one sample strobe; synchronized k_data is sampled on that cycle.
REQ-017 Frame format: 11 bits, in order: start=0, data[7:0] LSB first, odd parity, stop=1.
REQ-018 FSM states: IDLE, DATA (8 bits, 3-bit counter), PARITY, STOP. Transitions:
  - IDLE->DATA on a strobe with data=0.
  - A strobe with data=1 in IDLE SHALL be ignored, with no frame_err.
  - DATA->PARITY after the 8th bit.
  - PARITY->STOP on the next strobe.
  - STOP->IDLE on the next strobe.
REQ-019 Acceptance: when the stop bit is 1 and the 9-bit XOR of data plus parity is 1, the byte SHALL be accepted one cycle after the stop strobe.
REQ-020 Rejection: otherwise frame_err SHALL pulse, the byte SHALL be discarded, and the prefix flags SHALL be cleared.
REQ-021 Timeout: a counter runs in DATA, PARITY and STOP and resets on each strobe. On reaching TIMEOUT_CYC-1 it SHALL force IDLE, pulse frame_err and clear the prefix flags.
REQ-022 Prefix handling: an accepted E0 SHALL set the pending-extended flag; an accepted F0 SHALL set the pending-release flag. Neither SHALL pulse code_valid.
REQ-023 Other accepted bytes: code=byte; code_valid=1; extended and released take the pending flags; both pending flags then clear in the same cycle.
REQ-024 up SHALL pulse together with code_valid when code=75h, extended=1 and released=0; down likewise for 72h.
REQ-025 Any released=1 or extended=0 case SHALL produce no up/down pulse.
REQ-026 Qualifier persistence: code, extended and released SHALL hold their values until the next code_valid.
REQ-027 Latency: code_valid/up/down SHALL be asserted exactly 1 cycle after the clk cycle carrying the stop strobe.
REQ-028 Edge case: a strobe arriving in the same cycle as the timeout terminal count SHALL win; the counter resets and no error is raised.

Reset
REQ-029 With rst_n=0 sampled on a clk edge, the following SHALL all be 0: code, code_valid, extended, released, up, down, frame_err, the pending flags, the bit counter and the timeout counter.
REQ-030 On the same reset edge the FSM SHALL go to IDLE.
REQ-031 On the same reset edge the synchronizer and filter SHALL be loaded to 1 (bus idle-high).
REQ-032 Reset mid-frame SHALL discard the partial byte with no frame_err; the next start bit begins a fresh frame.

Structure
REQ-033 A shared game package SHALL hold the scan-code constants (E0h, F0h, 75h, 72h) and the FSM state encoding, for reuse by the game controller's keyboard-driven transitions.
REQ-034 A single sub-module ps2_sync_filter SHALL contain the synchronizers, the glitch filter and the falling-edge strobe; the frame FSM and prefix logic stay in ps2_key_decoder.

Verification
REQ-035 Frame of byte 1Ch, parity 0, stop 1 -> code=1Ch, code_valid 1 cycle, extended=0, released=0, no up/down.
REQ-036 Frames E0 then 75 -> up pulses once with code_valid, code=75h, extended=1; down stays 0.
REQ-037 Frames E0, F0, 72 -> code_valid with code=72h, extended=1, released=1; down stays 0.
REQ-038 Frame 1Ch with wrong parity -> frame_err pulse, no code_valid. Then frame 72h without E0 -> code_valid, no down.
REQ-039 Start bit plus 3 data bits, then k_clk held high for 50000 cycles -> frame_err pulse; the next full frame decodes correctly.
REQ-040 1-cycle k_clk low glitches (FILTER_LEN=4) -> no strobe. rst_n=0 mid-frame -> all outputs 0, the next frame decodes correctly.
